wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the WB stage and the X3 stage.
// Deferred X3 results wait in a 2-entry in-order buffer; WB always has priority.
module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        WB_RegWrite,
    input  logic [4:0]  WB_WriteReg,
    input  logic [31:0] WB_WriteData,
    input  logic        X3_RegWrite,
    input  logic [4:0]  X3_WriteReg,
    input  logic [31:0] X3_WriteData,
    output logic        RF_RegWrite,
    output logic [4:0]  RF_WriteReg,
    output logic [31:0] RF_WriteData,
    output logic        X_Stall,
    output logic [31:0] Pending_Mask,
    output logic [1:0]  Buf_Count,
    output logic        Starve_Req
);

    localparam int CW_RAW = $clog2(STARVE_LIMIT + 1);
    localparam int CW     = (CW_RAW > 3) ? CW_RAW : 3;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    // Buffer is kept compacted: entry 0 is the head, entries [0..cnt_r-1] are valid.
    logic [1:0][4:0]  reg_r;
    logic [1:0][4:0]  reg_n_s;
    logic [1:0][31:0] dat_r;
    logic [1:0][31:0] dat_n_s;
    logic [1:0]       cnt_r;
    logic [1:0]       cnt_n_s;
    logic [CW-1:0]    wait_r;
    logic [CW-1:0]    wait_n_s;
    logic             x_stall_r;
    logic             starve_r;
    logic             starve_n_s;

    logic wb_req_s;
    logic x3_req_s;
    logic pop_s;
    logic bypass_s;
    logic push_s;
    logic keep0_s;
    logic keep1_s;

    assign wb_req_s = Rst & WB_RegWrite & (WB_WriteReg != 5'd0);
    assign x3_req_s = Rst & X3_RegWrite & (X3_WriteReg != 5'd0) & ~x_stall_r;
    assign pop_s    = Rst & ~wb_req_s & (cnt_r != 2'd0);
    assign bypass_s = ~wb_req_s & (cnt_r == 2'd0) & x3_req_s;
    assign push_s   = x3_req_s & ~bypass_s & ~(wb_req_s & (X3_WriteReg == WB_WriteReg));
    // A WB write kills any buffered entry to the same register (WAW)
    assign keep0_s  = (cnt_r != 2'd0) & ~pop_s & ~(wb_req_s & (reg_r[0] == WB_WriteReg));
    assign keep1_s  = (cnt_r == 2'd2) & ~(wb_req_s & (reg_r[1] == WB_WriteReg));

    // Write-port grant mux: WB, then buffer head, then X3 bypass
    always_comb begin
        RF_RegWrite  = 1'b0;
        RF_WriteReg  = 5'd0;
        RF_WriteData = 32'd0;
        if (wb_req_s) begin
            RF_RegWrite  = 1'b1;
            RF_WriteReg  = WB_WriteReg;
            RF_WriteData = WB_WriteData;
        end else if (pop_s) begin
            RF_RegWrite  = 1'b1;
            RF_WriteReg  = reg_r[0];
            RF_WriteData = dat_r[0];
        end else if (bypass_s) begin
            RF_RegWrite  = 1'b1;
            RF_WriteReg  = X3_WriteReg;
            RF_WriteData = X3_WriteData;
        end else begin
            RF_RegWrite  = 1'b0;
        end
    end

    // Next buffer contents: drop popped/killed entries, compact, then append X3
    always_comb begin
        reg_n_s = reg_r;
        dat_n_s = dat_r;
        cnt_n_s = 2'd0;
        if (keep0_s) begin
            cnt_n_s = keep1_s ? 2'd2 : 2'd1;
        end else if (keep1_s) begin
            reg_n_s[0] = reg_r[1];
            dat_n_s[0] = dat_r[1];
            cnt_n_s    = 2'd1;
        end else begin
            cnt_n_s = 2'd0;
        end
        if (push_s && (cnt_n_s == 2'd0)) begin
            reg_n_s[0] = X3_WriteReg;
            dat_n_s[0] = X3_WriteData;
            cnt_n_s    = 2'd1;
        end else if (push_s && (cnt_n_s == 2'd1)) begin
            reg_n_s[1] = X3_WriteReg;
            dat_n_s[1] = X3_WriteData;
            cnt_n_s    = 2'd2;
        end else begin
            cnt_n_s = cnt_n_s;
        end
    end

    // Head wait counter and starvation request
    always_comb begin
        wait_n_s   = wait_r;
        starve_n_s = 1'b0;
        if ((cnt_r == 2'd0) || pop_s) begin
            wait_n_s = {CW{1'b0}};
        end else if (wait_r < LIMIT) begin
            wait_n_s = wait_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            wait_n_s = wait_r;
        end
        if (!pop_s && (cnt_r != 2'd0) && (wait_r == LIMIT)) begin
            starve_n_s = 1'b1;
        end else begin
            starve_n_s = 1'b0;
        end
    end

    // Pending-write mask for the hazard unit; register 0 never appears
    always_comb begin
        Pending_Mask = 32'd0;
        if (Rst) begin
            if (cnt_r != 2'd0) begin
                Pending_Mask[reg_r[0]] = 1'b1;
            end else begin
                Pending_Mask = Pending_Mask;
            end
            if (cnt_r == 2'd2) begin
                Pending_Mask[reg_r[1]] = 1'b1;
            end else begin
                Pending_Mask = Pending_Mask;
            end
            Pending_Mask[0] = 1'b0;
        end else begin
            Pending_Mask = 32'd0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            reg_r     <= '0;
            dat_r     <= '0;
            cnt_r     <= 2'd0;
            wait_r    <= {CW{1'b0}};
            x_stall_r <= 1'b0;
            starve_r  <= 1'b0;
        end else begin
            reg_r     <= reg_n_s;
            dat_r     <= dat_n_s;
            cnt_r     <= cnt_n_s;
            wait_r    <= wait_n_s;
            x_stall_r <= (cnt_n_s == 2'd2);
            starve_r  <= starve_n_s;
        end
    end

    assign X_Stall    = x_stall_r;
    assign Starve_Req = starve_r;
    assign Buf_Count  = cnt_r;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench: stimulus pushes hand-computed RF writes into a queue, a negedge
// monitor pops and compares every write; buffer status is checked after edges.
module tb_wb_port_arbiter;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        WB_RegWrite;
    logic [4:0]  WB_WriteReg;
    logic [31:0] WB_WriteData;
    logic        X3_RegWrite;
    logic [4:0]  X3_WriteReg;
    logic [31:0] X3_WriteData;
    logic        RF_RegWrite;
    logic [4:0]  RF_WriteReg;
    logic [31:0] RF_WriteData;
    logic        X_Stall;
    logic [31:0] Pending_Mask;
    logic [1:0]  Buf_Count;
    logic        Starve_Req;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .Clk(Clk), .Rst(Rst),
        .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg), .WB_WriteData(WB_WriteData),
        .X3_RegWrite(X3_RegWrite), .X3_WriteReg(X3_WriteReg), .X3_WriteData(X3_WriteData),
        .RF_RegWrite(RF_RegWrite), .RF_WriteReg(RF_WriteReg), .RF_WriteData(RF_WriteData),
        .X_Stall(X_Stall), .Pending_Mask(Pending_Mask), .Buf_Count(Buf_Count),
        .Starve_Req(Starve_Req)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every presented write must match the oldest expected write
    always @(negedge Clk) begin
        wr_t e;
        if (RF_RegWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got r%0d=0x%0h expected no write", RF_WriteReg, RF_WriteData);
            end else begin
                e = exp_q.pop_front();
                chk("rf_write", {27'd0, RF_WriteReg, RF_WriteData}, {27'd0, e.r, e.d});
            end
        end else begin
            chk("rf_idle_zero", {27'd0, RF_WriteReg, RF_WriteData}, 64'd0);
        end
    end

    task automatic cyc(input logic rst,
                       input logic wb, input logic [4:0] wr, input logic [31:0] wd,
                       input logic x3, input logic [4:0] xr, input logic [31:0] xd,
                       input logic ev, input logic [4:0] er, input logic [31:0] ed);
        Rst          = rst;
        WB_RegWrite  = wb;
        WB_WriteReg  = wr;
        WB_WriteData = wd;
        X3_RegWrite  = x3;
        X3_WriteReg  = xr;
        X3_WriteData = xd;
        if (ev) exp_q.push_back({er, ed});
        @(negedge Clk);
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input logic ev, input logic [4:0] er, input logic [31:0] ed);
        cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ev, er, ed);
    endtask

    task automatic st(input string name, input logic [1:0] cnt, input logic xs,
                      input logic [31:0] pm, input logic sr);
        chk({name, "_count"}, {62'd0, Buf_Count}, {62'd0, cnt});
        chk({name, "_xstall"}, {63'd0, X_Stall}, {63'd0, xs});
        chk({name, "_pending"}, {32'd0, Pending_Mask}, {32'd0, pm});
        chk({name, "_starve"}, {63'd0, Starve_Req}, {63'd0, sr});
    endtask

    initial begin
        Rst = 1'b0; WB_RegWrite = 1'b0; WB_WriteReg = 5'd0; WB_WriteData = 32'd0;
        X3_RegWrite = 1'b0; X3_WriteReg = 5'd0; X3_WriteData = 32'd0;
        @(posedge Clk);
        #1;
        // Reset held with requests present: no write may reach the register file
        cyc(1'b0, 1'b1, 5'd1, 32'h99, 1'b1, 5'd2, 32'h98, 1'b0, 5'd0, 32'd0);
        st("reset", 2'd0, 1'b0, 32'h0, 1'b0);

        // Bypass
        cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234, 1'b1, 5'd5, 32'h1234);
        st("bypass", 2'd0, 1'b0, 32'h0, 1'b0);

        // Destination 0 is no request
        cyc(1'b1, 1'b1, 5'd0, 32'h77, 1'b1, 5'd0, 32'h88, 1'b0, 5'd0, 32'd0);
        st("r0", 2'd0, 1'b0, 32'h0, 1'b0);

        // Collision: WB wins, X3 buffered then drained
        cyc(1'b1, 1'b1, 5'd3, 32'hA, 1'b1, 5'd7, 32'hB, 1'b1, 5'd3, 32'hA);
        st("coll1", 2'd1, 1'b0, 32'h80, 1'b0);
        idle(1'b1, 5'd7, 32'hB);
        st("coll2", 2'd0, 1'b0, 32'h0, 1'b0);

        // Same destination in one cycle: X3 discarded
        cyc(1'b1, 1'b1, 5'd6, 32'h11, 1'b1, 5'd6, 32'h22, 1'b1, 5'd6, 32'h11);
        st("same_dst", 2'd0, 1'b0, 32'h0, 1'b0);
        idle(1'b0, 5'd0, 32'd0);

        // Full buffer and X_Stall
        cyc(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd8, 32'h8, 1'b1, 5'd1, 32'h1);
        st("full1", 2'd1, 1'b0, 32'h100, 1'b0);
        cyc(1'b1, 1'b1, 5'd2, 32'h2, 1'b1, 5'd9, 32'h9, 1'b1, 5'd2, 32'h2);
        st("full2", 2'd2, 1'b1, 32'h300, 1'b0);
        cyc(1'b1, 1'b1, 5'd1, 32'h3, 1'b1, 5'd10, 32'hA0, 1'b1, 5'd1, 32'h3);
        st("full3", 2'd2, 1'b1, 32'h300, 1'b0);
        cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hA0, 1'b1, 5'd8, 32'h8);
        st("full4", 2'd1, 1'b0, 32'h200, 1'b0);
        cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hA0, 1'b1, 5'd9, 32'h9);
        st("pushpop", 2'd1, 1'b0, 32'h400, 1'b0);
        idle(1'b1, 5'd10, 32'hA0);
        st("full_drain", 2'd0, 1'b0, 32'h0, 1'b0);

        // WAW kill of the only entry
        cyc(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd4, 32'h44, 1'b1, 5'd1, 32'h1);
        st("waw1", 2'd1, 1'b0, 32'h10, 1'b0);
        cyc(1'b1, 1'b1, 5'd4, 32'h55, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h55);
        st("waw2", 2'd0, 1'b0, 32'h0, 1'b0);
        idle(1'b0, 5'd0, 32'd0);

        // WAW kill of the head keeps the tail
        cyc(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd11, 32'hB1, 1'b1, 5'd1, 32'h1);
        cyc(1'b1, 1'b1, 5'd2, 32'h2, 1'b1, 5'd12, 32'hC1, 1'b1, 5'd2, 32'h2);
        st("waw_head1", 2'd2, 1'b1, 32'h1800, 1'b0);
        cyc(1'b1, 1'b1, 5'd11, 32'h5, 1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'h5);
        st("waw_head2", 2'd1, 1'b0, 32'h1000, 1'b0);
        idle(1'b1, 5'd12, 32'hC1);
        st("waw_head3", 2'd0, 1'b0, 32'h0, 1'b0);

        // Starvation
        cyc(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd13, 32'hD, 1'b1, 5'd1, 32'h1);
        for (int i = 1; i <= 4; i++)
            cyc(1'b1, 1'b1, 5'd2, 32'(i), 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'(i));
        st("starve4", 2'd1, 1'b0, 32'h2000, 1'b0);
        cyc(1'b1, 1'b1, 5'd2, 32'h5, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h5);
        st("starve5", 2'd1, 1'b0, 32'h2000, 1'b1);
        cyc(1'b1, 1'b1, 5'd2, 32'h6, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h6);
        st("starve6", 2'd1, 1'b0, 32'h2000, 1'b1);
        idle(1'b1, 5'd13, 32'hD);
        st("starve_pop", 2'd0, 1'b0, 32'h0, 1'b0);

        // Reset mid-operation with a full buffer
        cyc(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd14, 32'hE, 1'b1, 5'd1, 32'h1);
        cyc(1'b1, 1'b1, 5'd2, 32'h2, 1'b1, 5'd15, 32'hF, 1'b1, 5'd2, 32'h2);
        st("prereset", 2'd2, 1'b1, 32'hC000, 1'b0);
        Rst = 1'b0;
        WB_RegWrite = 1'b0;
        X3_RegWrite = 1'b0;
        #1;
        chk("rst_pending", {32'd0, Pending_Mask}, 64'd0);
        chk("rst_rfwrite", {63'd0, RF_RegWrite}, 64'd0);
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        st("midreset", 2'd0, 1'b0, 32'h0, 1'b0);
        idle(1'b0, 5'd0, 32'd0);
        idle(1'b0, 5'd0, 32'd0);
        st("postreset", 2'd0, 1'b0, 32'h0, 1'b0);

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
